// File: rtl/ibex_lsu_data_if.sv
// Data-side load/store unit: turns one LSU request into one or two bus beats,
// rotates store data onto the byte lanes and reassembles/extends load data.
module ibex_lsu_data_if (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_type_i,
  input  logic        lsu_sign_ext_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [31:0] adder_result_ex_i,
  output logic        lsu_req_done_o,
  output logic        lsu_busy_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  input  logic [31:0] data_rdata_i,
  output logic [31:0] rf_wdata_lsu_o,
  output logic        rf_we_lsu_o,
  output logic        lsu_resp_valid_o,
  output logic        lsu_resp_err_o
);

  typedef enum logic [2:0] {
    IDLE, WAIT_GNT_MIS, WAIT_RVALID_MIS, WAIT_GNT, WAIT_RVALID
  } state_e;

  state_e      state_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  type_q;
  logic        we_q, sign_ext_q, err_q, second_q;

  logic        idle, is_half, is_byte, is_word, split, use_beat2, resp_fire;
  logic [31:0] cur_addr, wdata_rot, cur_wdata, ld_word;
  logic [1:0]  cur_type, off;
  logic [4:0]  sh;
  logic        cur_we;
  logic [3:0]  be_beat1, be_beat2;
  logic [63:0] ld_cat;
  logic [31:0] ld_ext;

  // In IDLE the bus is fed straight from the request; afterwards from the latched copy.
  assign idle      = (state_q == IDLE);
  assign cur_addr  = idle ? adder_result_ex_i : addr_q;
  assign cur_type  = idle ? lsu_type_i : type_q;
  assign cur_we    = idle ? lsu_we_i : we_q;
  assign off       = cur_addr[1:0];
  assign sh        = {off, 3'b000};
  assign is_half   = (cur_type == 2'b01);
  assign is_byte   = (cur_type == 2'b10);
  assign is_word   = ~is_half & ~is_byte;
  assign split     = (is_word & (off != 2'd0)) | (is_half & (off == 2'd3));
  assign wdata_rot = (lsu_wdata_i << sh) | (lsu_wdata_i >> (6'd32 - {1'b0, sh}));
  assign cur_wdata = idle ? wdata_rot : wdata_q;
  assign use_beat2 = (state_q == WAIT_GNT) & second_q;

  always_comb begin
    be_beat1 = 4'b1111 << off;
    be_beat2 = 4'b1111 >> (3'd4 - {1'b0, off});
    if (is_half) begin
      be_beat1 = 4'b0011 << off;
      be_beat2 = 4'b0001;
    end else if (is_byte) begin
      be_beat1 = 4'b0001 << off;
    end
  end

  always_comb begin
    case (state_q)
      IDLE:                   data_req_o = lsu_req_i;
      WAIT_GNT_MIS, WAIT_GNT: data_req_o = 1'b1;
      default:                data_req_o = 1'b0;
    endcase
  end

  assign data_addr_o    = !data_req_o ? 32'd0 :
                          use_beat2 ? {addr_q[31:2] + 30'd1, 2'b00} : {cur_addr[31:2], 2'b00};
  assign data_be_o      = !data_req_o ? 4'd0 : (use_beat2 ? be_beat2 : be_beat1);
  assign data_we_o      = data_req_o & cur_we;
  assign data_wdata_o   = data_req_o ? cur_wdata : 32'd0;
  assign lsu_req_done_o = data_gnt_i & ((idle & lsu_req_i & ~split) | (state_q == WAIT_GNT));
  assign lsu_busy_o     = ~idle;

  // The second beat's word sits above the first, so shifting the pair right by the offset aligns the load.
  assign resp_fire = (state_q == WAIT_RVALID) & data_rvalid_i;
  assign ld_cat    = second_q ? {data_rdata_i, rdata_q} : {32'd0, data_rdata_i};
  assign ld_word   = 32'(ld_cat >> sh);

  always_comb begin
    ld_ext = ld_word;
    if (is_half)      ld_ext = {{16{sign_ext_q & ld_word[15]}}, ld_word[15:0]};
    else if (is_byte) ld_ext = {{24{sign_ext_q & ld_word[7]}}, ld_word[7:0]};
  end

  assign lsu_resp_valid_o = resp_fire;
  assign lsu_resp_err_o   = resp_fire & (err_q | data_err_i);
  assign rf_we_lsu_o      = resp_fire & ~we_q & ~lsu_resp_err_o;
  assign rf_wdata_lsu_o   = rf_we_lsu_o ? ld_ext : 32'd0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      type_q     <= 2'd0;
      we_q       <= 1'b0;
      sign_ext_q <= 1'b0;
      err_q      <= 1'b0;
      second_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (lsu_req_i) begin
            addr_q     <= adder_result_ex_i;
            type_q     <= lsu_type_i;
            we_q       <= lsu_we_i;
            sign_ext_q <= lsu_sign_ext_i;
            wdata_q    <= wdata_rot;
            err_q      <= 1'b0;
            second_q   <= 1'b0;
            if (data_gnt_i) state_q <= split ? WAIT_RVALID_MIS : WAIT_RVALID;
            else            state_q <= split ? WAIT_GNT_MIS : WAIT_GNT;
          end
        end
        WAIT_GNT_MIS: begin
          if (data_gnt_i) state_q <= WAIT_RVALID_MIS;
        end
        WAIT_RVALID_MIS: begin
          if (data_rvalid_i) begin
            rdata_q  <= data_rdata_i;
            err_q    <= err_q | data_err_i;
            second_q <= 1'b1;
            state_q  <= WAIT_GNT;
          end
        end
        WAIT_GNT: begin
          if (data_gnt_i) state_q <= WAIT_RVALID;
        end
        WAIT_RVALID: begin
          if (data_rvalid_i) begin
            second_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_lsu_data_if.sv
// Bench for ibex_lsu_data_if: directed and random accesses checked against a
// byte-level model of which lanes each beat touches and what the load returns.
module tb_ibex_lsu_data_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lsuReq = 1'b0, lsuWe = 1'b0, lsuSext = 1'b0;
  logic [1:0]  lsuType = 2'd0;
  logic [31:0] lsuWdata = 32'd0, lsuAddr = 32'd0;
  logic        done, busy, dataReq, dataWe;
  logic        dataGnt = 1'b0, dataRvalid = 1'b0, dataErr = 1'b0;
  logic [31:0] dataAddr, dataWdata, dataRdata = 32'd0, rfWdata;
  logic [3:0]  dataBe;
  logic        rfWe, respValid, respErr;
  int          checkCount = 0;
  int          failCount = 0;

  ibex_lsu_data_if dut (
    .clk_i(clk), .rst_i(rst),
    .lsu_req_i(lsuReq), .lsu_we_i(lsuWe), .lsu_type_i(lsuType),
    .lsu_sign_ext_i(lsuSext), .lsu_wdata_i(lsuWdata), .adder_result_ex_i(lsuAddr),
    .lsu_req_done_o(done), .lsu_busy_o(busy),
    .data_req_o(dataReq), .data_gnt_i(dataGnt), .data_addr_o(dataAddr),
    .data_we_o(dataWe), .data_be_o(dataBe), .data_wdata_o(dataWdata),
    .data_rvalid_i(dataRvalid), .data_err_i(dataErr), .data_rdata_i(dataRdata),
    .rf_wdata_lsu_o(rfWdata), .rf_we_lsu_o(rfWe),
    .lsu_resp_valid_o(respValid), .lsu_resp_err_o(respErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // One response cycle window: rd cycles idle, then rvalid with data/err.
  task automatic respond(input int rd, input logic [31:0] rdata, input logic err,
                         input logic isFinal, input logic dropReq,
                         input logic expErr, input logic expWe, input logic [31:0] expData);
    for (int k = 0; k <= rd; k++) begin
      @(negedge clk);
      if (dropReq) lsuReq = 1'b0;
      dataGnt    = 1'b0;
      dataRvalid = (k == rd);
      dataRdata  = (k == rd) ? rdata : $urandom;
      dataErr    = (k == rd) ? err : 1'b0;
      #1;
      checkOutput("rsp_req", dataReq, 1'b0);
      checkOutput("rsp_busy", busy, 1'b1);
      checkOutput("rsp_valid", respValid, isFinal && (k == rd));
      if (isFinal && (k == rd)) begin
        checkOutput("rsp_err", respErr, expErr);
        checkOutput("rf_we", rfWe, expWe);
        checkOutput("rf_wdata", rfWdata, expData);
      end else begin
        checkOutput("rf_we_idle", rfWe, 1'b0);
      end
    end
  endtask

  // Grant window for one beat: g cycles of stall then a grant.
  task automatic grantBeat(input int g, input string tag, input logic firstBeat,
                           input logic [31:0] expAddr, input logic [3:0] expBe,
                           input logic [31:0] expWdata, input logic expDone);
    for (int k = 0; k <= g; k++) begin
      @(negedge clk);
      lsuReq     = 1'b1;
      dataGnt    = (k == g);
      dataRvalid = 1'b0;
      dataErr    = 1'b0;
      #1;
      checkOutput({tag, "_req"}, dataReq, 1'b1);
      checkOutput({tag, "_addr"}, dataAddr, expAddr);
      checkOutput({tag, "_be"}, dataBe, expBe);
      checkOutput({tag, "_we"}, dataWe, lsuWe);
      checkOutput({tag, "_wdata"}, dataWdata, expWdata);
      checkOutput({tag, "_busy"}, busy, !(firstBeat && k == 0));
      checkOutput({tag, "_done"}, done, expDone && (k == g));
    end
  endtask

  // Full access: model derives the beats byte by byte, then drives and checks the bus.
  task automatic applyStimulus(input logic we, input logic [1:0] typ, input logic sext,
                               input logic [31:0] wdata, input logic [31:0] addr,
                               input int g1, input int r1, input logic [31:0] rd1, input logic e1,
                               input int g2, input int r2, input logic [31:0] rd2, input logic e2);
    int          size;
    logic [31:0] w1, w2, ba, wexp, lexp;
    logic [3:0]  be1, be2;
    logic        split, errAll;
    size  = (typ == 2'b01) ? 2 : (typ == 2'b10) ? 1 : 4;
    w1    = {addr[31:2], 2'b00};
    w2    = w1 + 32'd4;
    be1   = 4'd0;
    be2   = 4'd0;
    split = 1'b0;
    lexp  = 32'd0;
    for (int i = 0; i < size; i++) begin
      ba = addr + i;
      if ({ba[31:2], 2'b00} == w1) begin
        be1[ba[1:0]] = 1'b1;
        lexp[8*i +: 8] = rd1[8*ba[1:0] +: 8];
      end else begin
        be2[ba[1:0]] = 1'b1;
        split = 1'b1;
        lexp[8*i +: 8] = rd2[8*ba[1:0] +: 8];
      end
    end
    if (sext && lexp[8*size-1])
      for (int i = 8*size; i < 32; i++) lexp[i] = 1'b1;
    for (int l = 0; l < 4; l++)
      wexp[8*l +: 8] = wdata[8*((l - addr[1:0]) & 3) +: 8];
    errAll = e1 | (split & e2);
    if (we || errAll) lexp = 32'd0;

    lsuWe = we; lsuType = typ; lsuSext = sext; lsuWdata = wdata; lsuAddr = addr;
    grantBeat(g1, "b1", 1'b1, w1, be1, wexp, !split);
    if (split) begin
      respond(r1, rd1, e1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      grantBeat(g2, "b2", 1'b0, w2, be2, wexp, 1'b1);
      respond(r2, rd2, e2, 1'b1, 1'b1, errAll, !we && !errAll, lexp);
    end else begin
      respond(r1, rd1, e1, 1'b1, 1'b1, errAll, !we && !errAll, lexp);
    end
  endtask

  initial begin
    logic [31:0] ra;
    #1;
    checkOutput("rst_req", dataReq, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_rfwe", rfWe, 1'b0);
    checkOutput("rst_valid", respValid, 1'b0);
    checkOutput("rst_err", respErr, 1'b0);
    checkOutput("rst_addr", dataAddr, 32'd0);
    checkOutput("rst_be", dataBe, 4'd0);
    checkOutput("rst_wdata", dataWdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Stray rvalid while idle must not produce a response.
    @(negedge clk);
    dataRvalid = 1'b1;
    dataRdata  = 32'hCAFEF00D;
    #1;
    checkOutput("idle_rvalid", respValid, 1'b0);
    checkOutput("idle_rfwe", rfWe, 1'b0);

    applyStimulus(1'b0, 2'b00, 1'b0, 32'd0, 32'h100, 0, 0, 32'hDEADBEEF, 1'b0, 0, 0, 32'd0, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'd0, 32'h101, 0, 0, 32'h44332211, 1'b0, 1, 1, 32'h88776655, 1'b0);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'd0, 32'h203, 1, 0, 32'h80000000, 1'b0, 0, 0, 32'h000000FF, 1'b0);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'd0, 32'h203, 0, 1, 32'h80000000, 1'b0, 0, 0, 32'h000000FF, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h000000AB, 32'h302, 3, 0, 32'd0, 1'b0, 0, 0, 32'd0, 1'b0);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h11223344, 32'h0FE, 0, 0, 32'd0, 1'b1, 0, 0, 32'd0, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'd0, 32'hFFFFFFFE, 0, 0, 32'hA1B2C3D4, 1'b0, 0, 0, 32'h55667788, 1'b0);

    // Reset while waiting for the response, then a stale rvalid.
    @(negedge clk);
    lsuReq = 1'b1; lsuWe = 1'b0; lsuType = 2'b00; lsuAddr = 32'h400;
    dataGnt = 1'b1; dataRvalid = 1'b0;
    #1;
    checkOutput("mid_done", done, 1'b1);
    @(negedge clk);
    lsuReq = 1'b0; dataGnt = 1'b0;
    #1;
    checkOutput("mid_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_busy", busy, 1'b0);
    checkOutput("mid_rst_valid", respValid, 1'b0);
    @(negedge clk);
    rst = 1'b0; dataRvalid = 1'b1; dataRdata = 32'h12345678;
    #1;
    checkOutput("stale_valid", respValid, 1'b0);
    checkOutput("stale_busy", busy, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'd0, 32'h400, 0, 0, 32'h0BADF00D, 1'b0, 0, 0, 32'd0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra[31:4] = '1;
      applyStimulus(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), $urandom, ra,
                    $urandom_range(0, 2), $urandom_range(0, 2), $urandom, ($urandom_range(0, 7) == 0),
                    $urandom_range(0, 2), $urandom_range(0, 2), $urandom, ($urandom_range(0, 7) == 0));
    end

    @(negedge clk);
    lsuReq = 1'b0; dataRvalid = 1'b0;
    $display("test done: total=%0d bad=%0d", checkCount, failCount);
    $finish;
  end

endmodule
